// File: rtl/axi_write_buffer.sv
// Store write buffer: FIFO of pending stores drained as single-beat AXI writes, one at a time.
// Optional read forwarding is enabled by defining WRITE_BUFFER_FORWARD_EN.
module axi_write_buffer #(
   parameter int unsigned DEPTH  = 4,
   parameter logic [3:0]  AXI_ID = 4'b0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_req,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data,
   input  logic [3:0]  wr_sel,
   output logic        wr_addr_ok,
   output logic        buf_empty,
   input  logic [31:0] fwd_addr,
   output logic        fwd_hit,
   output logic [31:0] fwd_data,
   output logic [3:0]  fwd_sel,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StSend, StResp} state_t;

   state_t         r_state, w_state_nxt;
   logic [CW-1:0]  r_count;
   logic [PW-1:0]  r_head, r_tail;
   logic           r_aw_done, r_w_done;
   logic           w_aw_done_nxt, w_w_done_nxt;
   logic           w_push, w_pop;
   logic [31:0]    r_addr [DEPTH];
   logic [31:0]    r_data [DEPTH];
   logic [3:0]     r_sel  [DEPTH];

   assign wr_addr_ok = (r_count != FULL);
   assign buf_empty  = (r_count == '0) && (r_state == StIdle);
   assign w_push     = wr_req & wr_addr_ok;
   assign w_pop      = (r_state == StResp) & bvalid;

   assign awid    = AXI_ID;
   assign wid     = AXI_ID;
   assign awlen   = 4'd0;
   assign awsize  = 3'b010;
   assign awburst = 2'b01;
   assign awlock  = 2'd0;
   assign awcache = 4'd0;
   assign awprot  = 3'd0;
   assign wlast   = 1'b1;
   assign awaddr  = r_addr[r_head];
   assign wdata   = r_data[r_head];
   assign wstrb   = r_sel[r_head];
   assign awvalid = (r_state == StSend) & ~r_aw_done;
   assign wvalid  = (r_state == StSend) & ~r_w_done;
   assign bready  = (r_state == StResp);

   always_comb begin
      w_state_nxt   = r_state;
      w_aw_done_nxt = r_aw_done;
      w_w_done_nxt  = r_w_done;
      unique case (r_state)
         StIdle: if (r_count != '0) w_state_nxt = StSend;
         StSend: begin
            if (awvalid & awready) w_aw_done_nxt = 1'b1;
            if (wvalid & wready)   w_w_done_nxt  = 1'b1;
            // Both channels may complete in the same cycle.
            if (w_aw_done_nxt & w_w_done_nxt) begin
               w_state_nxt   = StResp;
               w_aw_done_nxt = 1'b0;
               w_w_done_nxt  = 1'b0;
            end
         end
         StResp: if (bvalid) w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= StIdle;
         r_count   <= '0;
         r_head    <= '0;
         r_tail    <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_aw_done <= w_aw_done_nxt;
         r_w_done  <= w_w_done_nxt;
         if (w_push) r_tail <= r_tail + PW'(1);
         if (w_pop)  r_head <= r_head + PW'(1);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_tail] <= wr_addr;
         r_data[r_tail] <= wr_data;
         r_sel[r_tail]  <= wr_sel;
      end
   end

`ifdef WRITE_BUFFER_FORWARD_EN
   logic [PW-1:0] w_idx;
   logic          w_unused_ok;
   assign w_unused_ok = ^{bid, bresp, fwd_addr[1:0]};

   // Walk oldest to youngest so the last match wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_sel  = '0;
      w_idx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = r_head + PW'(i);
         if ((CW'(i) < r_count) && (r_addr[w_idx][31:2] == fwd_addr[31:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = r_data[w_idx];
            fwd_sel  = r_sel[w_idx];
         end
      end
   end
`else
   logic w_unused_ok;
   assign w_unused_ok = ^{bid, bresp, fwd_addr};
   assign fwd_hit  = 1'b0;
   assign fwd_data = '0;
   assign fwd_sel  = '0;
`endif

endmodule

// File: tb/tb_axi_write_buffer.sv
// Directed bench for axi_write_buffer with a small behavioural AXI slave that logs
// AW/W beats and answers B one cycle after both handshakes.
module tb_axi_write_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_req;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_sel;
   logic        wr_addr_ok, buf_empty;
   logic [31:0] fwd_addr;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic [3:0]  fwd_sel;
   logic [3:0]  awid, awlen, awcache, wid, wstrb, bid;
   logic [31:0] awaddr, wdata;
   logic [2:0]  awsize, awprot;
   logic [1:0]  awburst, awlock, bresp;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

   int n_total = 0;
   int n_bad   = 0;

   logic        b_auto = 1'b1;
   logic        txn_aw = 1'b0;
   logic        txn_w  = 1'b0;
   int          b_cnt  = 0;
   logic [31:0] aw_log [$];
   logic [31:0] w_log  [$];

   always #5 clk = ~clk;

   axi_write_buffer #(
      .DEPTH  (4),
      .AXI_ID (4'hA)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .wr_req     (wr_req),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_sel     (wr_sel),
      .wr_addr_ok (wr_addr_ok),
      .buf_empty  (buf_empty),
      .fwd_addr   (fwd_addr),
      .fwd_hit    (fwd_hit),
      .fwd_data   (fwd_data),
      .fwd_sel    (fwd_sel),
      .awid       (awid),
      .awaddr     (awaddr),
      .awlen      (awlen),
      .awsize     (awsize),
      .awburst    (awburst),
      .awlock     (awlock),
      .awcache    (awcache),
      .awprot     (awprot),
      .awvalid    (awvalid),
      .awready    (awready),
      .wid        (wid),
      .wdata      (wdata),
      .wstrb      (wstrb),
      .wlast      (wlast),
      .wvalid     (wvalid),
      .wready     (wready),
      .bid        (bid),
      .bresp      (bresp),
      .bvalid     (bvalid),
      .bready     (bready)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Slave: handshakes are sampled on the negedge and take effect at the next posedge.
   initial begin
      logic        aw_f, w_f, b_f;
      logic [31:0] a, d;
      bvalid = 1'b0;
      forever begin
         @(negedge clk);
         aw_f = awvalid & awready;
         w_f  = wvalid & wready;
         b_f  = bvalid & bready;
         a    = awaddr;
         d    = wdata;
         @(posedge clk);
         #1;
         if (aw_f) begin aw_log.push_back(a); txn_aw = 1'b1; end
         if (w_f)  begin w_log.push_back(d);  txn_w  = 1'b1; end
         if (b_f) begin
            bvalid = 1'b0;
            b_cnt++;
         end else if (b_auto && txn_aw && txn_w && !bvalid) begin
            bvalid = 1'b1;
            txn_aw = 1'b0;
            txn_w  = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      wr_req  = 1'b1;
      wr_addr = a;
      wr_data = d;
      wr_sel  = s;
      tick();
      wr_req  = 1'b0;
   endtask

   task automatic clear_logs();
      aw_log.delete();
      w_log.delete();
      b_cnt  = 0;
      txn_aw = 1'b0;
      txn_w  = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int i = 0;
      while (!(buf_empty && !bvalid) && i < 200) begin
         tick();
         i++;
      end
      check_eq(tag, {31'd0, buf_empty}, 32'd1);
   endtask

   initial begin
      int n;
      rst      = 1'b1;
      wr_req   = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      wr_sel   = '0;
      fwd_addr = '0;
      awready  = 1'b0;
      wready   = 1'b0;
      bid      = 4'h3;
      bresp    = 2'b10;
      #1 rst = 1'b0;
      #1;
      check_eq("rst_wr_addr_ok", {31'd0, wr_addr_ok}, 32'd1);
      check_eq("rst_buf_empty",  {31'd0, buf_empty},  32'd1);
      check_eq("rst_awvalid",    {31'd0, awvalid},    32'd0);
      check_eq("rst_wvalid",     {31'd0, wvalid},     32'd0);
      check_eq("rst_bready",     {31'd0, bready},     32'd0);
      check_eq("rst_fwd_hit",    {31'd0, fwd_hit},    32'd0);
      check_eq("const_awid",     {28'd0, awid},       32'hA);
      check_eq("const_wid",      {28'd0, wid},        32'hA);
      check_eq("const_awsize",   {29'd0, awsize},     32'd2);
      check_eq("const_awburst",  {30'd0, awburst},    32'd1);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // Single store, immediate ready, B one cycle later.
      awready = 1'b1;
      wready  = 1'b1;
      clear_logs();
      push(32'h1FC0_0010, 32'hDEAD_BEEF, 4'hF);
      check_eq("single_lat_awvalid_n1", {31'd0, awvalid},   32'd0);
      check_eq("single_not_empty",      {31'd0, buf_empty}, 32'd0);
      tick();
      check_eq("single_awvalid_n2", {31'd0, awvalid}, 32'd1);
      check_eq("single_wvalid_n2",  {31'd0, wvalid},  32'd1);
      check_eq("single_awaddr",     awaddr,           32'h1FC0_0010);
      check_eq("single_wdata",      wdata,            32'hDEAD_BEEF);
      check_eq("single_wstrb",      {28'd0, wstrb},   32'hF);
      check_eq("single_awlen",      {28'd0, awlen},   32'd0);
      check_eq("single_wlast",      {31'd0, wlast},   32'd1);
      wait_idle("single_idle");
      check_eq("single_aw_count", aw_log.size(), 32'd1);
      check_eq("single_w_count",  w_log.size(),  32'd1);
      check_eq("single_b_count",  b_cnt,         32'd1);
      check_eq("single_aw_log",   aw_log[0],     32'h1FC0_0010);
      check_eq("single_w_log",    w_log[0],      32'hDEAD_BEEF);

      // Fill to DEPTH with AW stalled; fifth store waits for the first B.
      awready = 1'b0;
      wready  = 1'b1;
      clear_logs();
      for (int k = 0; k < 4; k++) begin
         wr_req  = 1'b1;
         wr_addr = 32'h1000 + 32'(k * 4);
         wr_data = 32'hA0 + 32'(k);
         wr_sel  = 4'hF;
         check_eq($sformatf("full_ok_%0d", k), {31'd0, wr_addr_ok}, 32'd1);
         tick();
      end
      wr_addr = 32'h2000;
      wr_data = 32'hB0;
      check_eq("full_ok_blocked", {31'd0, wr_addr_ok}, 32'd0);
      tick();
      tick();
      tick();
      check_eq("full_ok_still_blocked", {31'd0, wr_addr_ok}, 32'd0);
      check_eq("full_no_b_yet",         b_cnt,              32'd0);
      awready = 1'b1;
      n = 0;
      while (!wr_addr_ok && n < 50) begin
         tick();
         n++;
      end
      check_eq("full_ok_reopened", {31'd0, wr_addr_ok}, 32'd1);
      check_eq("full_b_before_5th", b_cnt, 32'd1);
      tick();
      wr_req = 1'b0;
      wait_idle("full_idle");
      check_eq("full_aw_count", aw_log.size(), 32'd5);
      for (int k = 0; k < 4; k++) begin
         check_eq($sformatf("full_aw_order_%0d", k), aw_log[k], 32'h1000 + 32'(k * 4));
         check_eq($sformatf("full_w_order_%0d", k),  w_log[k],  32'hA0 + 32'(k));
      end
      check_eq("full_aw_order_4", aw_log[4], 32'h2000);
      check_eq("full_w_order_4",  w_log[4],  32'hB0);
      check_eq("full_b_count",    b_cnt,     32'd5);

      // W accepted three cycles before AW.
      awready = 1'b0;
      wready  = 1'b1;
      clear_logs();
      push(32'h3000, 32'hCAFE_F00D, 4'h5);
      tick();
      check_eq("split_awvalid_start", {31'd0, awvalid}, 32'd1);
      check_eq("split_wvalid_start",  {31'd0, wvalid},  32'd1);
      tick();
      check_eq("split_wvalid_dropped", {31'd0, wvalid},  32'd0);
      check_eq("split_awvalid_held",   {31'd0, awvalid}, 32'd1);
      tick();
      tick();
      check_eq("split_awvalid_held2", {31'd0, awvalid}, 32'd1);
      check_eq("split_wvalid_low2",   {31'd0, wvalid},  32'd0);
      check_eq("split_awaddr_stable", awaddr,           32'h3000);
      check_eq("split_bready_low",    {31'd0, bready},  32'd0);
      awready = 1'b1;
      wait_idle("split_idle");
      check_eq("split_aw_count", aw_log.size(), 32'd1);
      check_eq("split_w_count",  w_log.size(),  32'd1);
      check_eq("split_b_count",  b_cnt,         32'd1);
      check_eq("split_w_data",   w_log[0],      32'hCAFE_F00D);
      check_eq("split_ok",       {31'd0, wr_addr_ok}, 32'd1);

      // Forwarding from pending stores to the same word.
      awready = 1'b0;
      wready  = 1'b0;
      clear_logs();
      push(32'h100, 32'h11, 4'hF);
      push(32'h100, 32'h22, 4'h3);
      fwd_addr = 32'h102;
      #1;
`ifdef WRITE_BUFFER_FORWARD_EN
      check_eq("fwd_hit",  {31'd0, fwd_hit}, 32'd1);
      check_eq("fwd_data", fwd_data,         32'h22);
      check_eq("fwd_sel",  {28'd0, fwd_sel}, 32'h3);
`else
      check_eq("fwd_hit",  {31'd0, fwd_hit}, 32'd0);
      check_eq("fwd_data", fwd_data,         32'h0);
      check_eq("fwd_sel",  {28'd0, fwd_sel}, 32'h0);
`endif
      fwd_addr = 32'h104;
      #1;
      check_eq("fwd_miss", {31'd0, fwd_hit}, 32'd0);
      fwd_addr = 32'h102;
      awready  = 1'b1;
      wready   = 1'b1;
      wait_idle("fwd_idle");
      check_eq("fwd_after_drain", {31'd0, fwd_hit}, 32'd0);
      check_eq("fwd_aw_count",    aw_log.size(),    32'd2);

      // Reset while waiting in RESP with three entries buffered.
      b_auto = 1'b0;
      clear_logs();
      wr_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wr_addr = 32'h5000 + 32'(k * 4);
         wr_data = 32'h50 + 32'(k);
         wr_sel  = 4'hF;
         tick();
      end
      wr_req = 1'b0;
      tick();
      check_eq("rstmid_bready_before", {31'd0, bready},     32'd1);
      check_eq("rstmid_not_empty",     {31'd0, buf_empty},  32'd0);
      rst = 1'b0;
      #1;
      check_eq("rstmid_awvalid",   {31'd0, awvalid},    32'd0);
      check_eq("rstmid_wvalid",    {31'd0, wvalid},     32'd0);
      check_eq("rstmid_bready",    {31'd0, bready},     32'd0);
      check_eq("rstmid_buf_empty", {31'd0, buf_empty},  32'd1);
      check_eq("rstmid_ok",        {31'd0, wr_addr_ok}, 32'd1);
      tick();
      rst = 1'b1;
      clear_logs();
      b_auto = 1'b1;
      tick();
      push(32'h4000, 32'h44, 4'hF);
      wait_idle("rstmid_idle");
      check_eq("rstmid_aw_count", aw_log.size(), 32'd1);
      check_eq("rstmid_aw_addr",  aw_log[0],     32'h4000);
      check_eq("rstmid_w_data",   w_log[0],      32'h44);
      check_eq("rstmid_b_count",  b_cnt,         32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
